adc_seq_scheduler: RTL
======================

Name: adc_seq_scheduler

Overview:
- Master-side controller for the ADC Qsys subsystem.
- Starts and stops the modular ADC sequencer by writing its command CSR through the Avalon-MM bridge slave.
- Consumes the ADC response stream and accumulates 2^AVG_LOG2 samples per channel for channels 0..NUM_CH-1.
- Presents each per-channel average on a valid/ready output port to downstream display/logging logic.

Parameters:
NUM_CH, 8, number of tracked channels (0..NUM_CH-1), range 1..17
AVG_LOG2, 4, log2 of samples averaged per result, range 0..6
SEQ_CMD_ADDR, 10'h000, bridge word address of sequencer command register
SEQ_MODE, 3'd0, sequencer mode field written on start (0 = continuous)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin conversion run
stop  in  1  one-cycle pulse; end conversion run
busy  out  1  high in any state other than IDLE
avm_address  out  10  bridge address
avm_write  out  1  bridge write strobe
avm_writedata  out  16  bridge write data
avm_byteenable  out  2  always 2'b11
avm_burstcount  out  1  always 1'b1
avm_read  out  1  tied 0
avm_waitrequest  in  1  bridge stall
rsp_valid  in  1  ADC response valid
rsp_channel  in  5  response channel
rsp_data  in  12  response sample
avg_valid  out  1  average available
avg_ready  in  1  downstream accept
avg_channel  out  5  channel of average
avg_data  out  12  averaged sample
overrun  out  1  sticky; an average was dropped

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is asynchronous and active-low on reset_reset_n.
- Reset values: all outputs 0 except avm_byteenable = 2'b11 and avm_burstcount = 1; FSM in IDLE; accumulators and counters cleared.
- FSM states: IDLE, CFG_WR, RUN, STOP_WR.
- IDLE:
  - start -> CFG_WR.
  - stop is ignored.
- CFG_WR:
  - avm_write = 1, avm_address = SEQ_CMD_ADDR, avm_writedata = {12'b0, SEQ_MODE, 1'b1}.
  - Hold all three while avm_waitrequest = 1.
  - Cycle with avm_waitrequest = 0 completes the write -> RUN.
  - start/stop are ignored in this state; a stop is not queued.
- RUN:
  - stop -> STOP_WR.
  - start is ignored.
- STOP_WR:
  - Same write as CFG_WR but with avm_writedata = 16'h0000 (run bit cleared).
  - On completion -> IDLE.
  - On entry to STOP_WR, all accumulators and counts clear; partial averages are discarded.
- Sample acceptance: only in RUN, only when rsp_valid = 1 and rsp_channel < NUM_CH. All other responses are dropped silently. The stream has no backpressure.
- Per-channel state:
  - acc[c] is 12+AVG_LOG2 bits; cnt[c] is AVG_LOG2 bits.
  - An accepted sample adds to acc[c] and increments cnt[c].
  - When cnt[c] reaches 2^AVG_LOG2-1 and a sample is accepted:
    - result = (acc[c] + sample) >> AVG_LOG2, truncating.
    - acc[c] and cnt[c] clear in the same cycle.
  - AVG_LOG2 = 0: every accepted sample is a result.
- Latency: the result is registered, so avg_valid rises 1 cycle after the completing sample.
- Output register handshake:
  - avg_valid, avg_channel, avg_data hold until avg_valid && avg_ready.
  - If a new result completes while the register is occupied and not being accepted that cycle, the new result is dropped and overrun is set.
  - If the register is accepted in the same cycle a new result completes, the new result loads with no overrun.
- overrun clears only on reset.
- The output register is not flushed by stop; a pending average remains valid.
- Reset mid-write: avm_write drops immediately (asynchronous reset); the bridge transaction is abandoned.
- start and stop asserted in the same cycle: the state-appropriate one applies (start in IDLE, stop in RUN).

Decomposition:
- Package adc_seq_pkg holds:
  - state enum (IDLE, CFG_WR, RUN, STOP_WR);
  - localparams for CMD bit positions (RUN_BIT = 0, MODE_LSB = 1, MODE_W = 3);
  - ADC_DATA_W = 12, ADC_CH_W = 5, CSR_DATA_W = 16, CSR_ADDR_W = 10.
- One sub-module, adc_ch_accum: the per-channel accumulator array plus the result generator. The top keeps the FSM, bridge master and output register.

Test Plan:
- Start with waitrequest held 3 cycles -> avm_write held exactly 4 cycles, addr 0x000, data 0x0001; busy = 1; state RUN afterwards.
- AVG_LOG2 = 2, RUN, channel 3 samples 100, 101, 102, 105 -> one avg_valid, channel 3, data 102 (408 >> 2); acc cleared.
- Interleaved channels 0 and 1, four samples each of 4095 -> two results of 4095, one per channel, in completion order; a channel-9 sample with NUM_CH = 8 is ignored.
- avg_ready = 0 with a result pending, then a second result completes -> second result dropped, overrun = 1, first result data unchanged.
- Stop after 2 of 4 samples on channel 5 -> write data 0x0000, return to IDLE; after restart, 4 fresh samples of 8 give 8, not a mix with the old partial sum.
- reset_reset_n low during CFG_WR stall -> avm_write = 0 asynchronously; FSM in IDLE; busy = 0; overrun = 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sequencer scheduler: FSM states,
// sequencer command-word layout and bus widths.
package adc_seq_pkg;

  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_CH_W   = 5;
  localparam int unsigned CSR_DATA_W = 16;
  localparam int unsigned CSR_ADDR_W = 10;

  localparam int unsigned RUN_BIT  = 0;
  localparam int unsigned MODE_LSB = 1;
  localparam int unsigned MODE_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CFG_WR  = 2'd1,
    RUN     = 2'd2,
    STOP_WR = 2'd3
  } state_e;

  // Sequencer command CSR word: run bit plus mode field, all other bits zero.
  function automatic logic [CSR_DATA_W-1:0] cmd_word(input logic run,
                                                     input logic [MODE_W-1:0] mode);
    logic [CSR_DATA_W-1:0] w;
    w                    = '0;
    w[RUN_BIT]           = run;
    w[MODE_LSB +: MODE_W] = mode;
    return w;
  endfunction

endpackage

// File: rtl/adc_ch_accum.sv
// Per-channel sample accumulators; flags a result combinationally in the cycle
// the 2^AVG_LOG2-th sample of a channel is accepted.
module adc_ch_accum
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  acc_en_i,
  input  logic [ADC_CH_W-1:0]   ch_i,
  input  logic [ADC_DATA_W-1:0] data_i,
  output logic                  res_valid_c,
  output logic [ADC_CH_W-1:0]   res_ch_c,
  output logic [ADC_DATA_W-1:0] res_data_c
);

  localparam int unsigned ACC_W = ADC_DATA_W + AVG_LOG2;
  // A zero-width count is not legal; with AVG_LOG2 = 0 the count stays at 0.
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  logic [ACC_W-1:0] acc_sel;
  logic [CNT_W-1:0] cnt_sel;
  logic [ACC_W-1:0] sum;
  logic             last;

  // Select the addressed channel and form the running sum.
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ch_i == ADC_CH_W'(c)) begin
        acc_sel = acc_q[c];
        cnt_sel = cnt_q[c];
      end
    end
    sum         = acc_sel + ACC_W'(data_i);
    last        = (cnt_sel == CNT_LAST);
    res_valid_c = acc_en_i && !clr_i && last;
    res_ch_c    = ch_i;
    res_data_c  = ADC_DATA_W'(sum >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (clr_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else if (acc_en_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_i == ADC_CH_W'(c)) begin
          if (last) begin
            acc_q[c] <= '0;
            cnt_q[c] <= '0;
          end else begin
            acc_q[c] <= sum;
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/adc_seq_scheduler.sv
// Master-side ADC sequencer controller: starts/stops the sequencer over the
// Avalon-MM bridge, averages per-channel samples and presents them valid/ready.
module adc_seq_scheduler
  import adc_seq_pkg::*;
#(
  parameter int unsigned            NUM_CH       = 8,
  parameter int unsigned            AVG_LOG2     = 4,
  parameter logic [CSR_ADDR_W-1:0]  SEQ_CMD_ADDR = 10'h000,
  parameter logic [MODE_W-1:0]      SEQ_MODE     = 3'd0
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic [CSR_ADDR_W-1:0] avm_address,
  output logic                  avm_write,
  output logic [CSR_DATA_W-1:0] avm_writedata,
  output logic [1:0]            avm_byteenable,
  output logic                  avm_burstcount,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic                  rsp_valid,
  input  logic [ADC_CH_W-1:0]   rsp_channel,
  input  logic [ADC_DATA_W-1:0] rsp_data,
  output logic                  avg_valid,
  input  logic                  avg_ready,
  output logic [ADC_CH_W-1:0]   avg_channel,
  output logic [ADC_DATA_W-1:0] avg_data,
  output logic                  overrun
);

  state_e                  state_q;
  logic                    busy_q;
  logic                    avm_write_q;
  logic [CSR_ADDR_W-1:0]   avm_address_q;
  logic [CSR_DATA_W-1:0]   avm_writedata_q;

  logic                    avg_valid_q;
  logic [ADC_CH_W-1:0]     avg_channel_q;
  logic [ADC_DATA_W-1:0]   avg_data_q;
  logic                    overrun_q;

  logic                    acc_clr;
  logic                    acc_en;
  logic                    res_valid_c;
  logic [ADC_CH_W-1:0]     res_ch_c;
  logic [ADC_DATA_W-1:0]   res_data_c;

  // Partial sums are discarded on the transition into STOP_WR.
  assign acc_clr = (state_q == RUN) && stop;
  assign acc_en  = (state_q == RUN) && rsp_valid && (rsp_channel < ADC_CH_W'(NUM_CH));

  adc_ch_accum #(
    .NUM_CH   (NUM_CH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .clr_i       (acc_clr),
    .acc_en_i    (acc_en),
    .ch_i        (rsp_channel),
    .data_i      (rsp_data),
    .res_valid_c (res_valid_c),
    .res_ch_c    (res_ch_c),
    .res_data_c  (res_data_c)
  );

  // Control FSM with registered bridge-master outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q         <= CFG_WR;
            busy_q          <= 1'b1;
            avm_write_q     <= 1'b1;
            avm_address_q   <= SEQ_CMD_ADDR;
            avm_writedata_q <= cmd_word(1'b1, SEQ_MODE);
          end
        end
        CFG_WR: begin
          if (!avm_waitrequest) begin
            state_q     <= RUN;
            avm_write_q <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q         <= STOP_WR;
            avm_write_q     <= 1'b1;
            avm_address_q   <= SEQ_CMD_ADDR;
            avm_writedata_q <= cmd_word(1'b0, '0);
          end
        end
        STOP_WR: begin
          if (!avm_waitrequest) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            avm_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          avm_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output register; a result arriving while it is held is dropped.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avg_valid_q   <= 1'b0;
      avg_channel_q <= '0;
      avg_data_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      if (res_valid_c && (!avg_valid_q || avg_ready)) begin
        avg_valid_q   <= 1'b1;
        avg_channel_q <= res_ch_c;
        avg_data_q    <= res_data_c;
      end else begin
        if (res_valid_c) begin
          overrun_q <= 1'b1;
        end
        if (avg_valid_q && avg_ready) begin
          avg_valid_q <= 1'b0;
        end
      end
    end
  end

  assign busy           = busy_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = 2'b11;
  assign avm_burstcount = 1'b1;
  assign avm_read       = 1'b0;
  assign avg_valid      = avg_valid_q;
  assign avg_channel    = avg_channel_q;
  assign avg_data       = avg_data_q;
  assign overrun        = overrun_q;

endmodule
